// File: rtl/kd_tree_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kd_tree_pkg
//  Purpose  : Shared widths, types and helpers for the k-d tree decision node.
//  Contents : ELEM_W, NUM_ELEM, default DATA_WIDTH/STORAGE_WIDTH,
//             elem_t (signed patch element), split_cfg_t {median, index},
//             pack_split() helper that builds a configuration word.
//  Revision : 1.0 - initial release
// ============================================================================
package kd_tree_pkg;

    localparam int DATA_WIDTH_DEFAULT    = 55;
    localparam int STORAGE_WIDTH_DEFAULT = 22;
    localparam int ELEM_W                = STORAGE_WIDTH_DEFAULT / 2;
    localparam int NUM_ELEM              = DATA_WIDTH_DEFAULT / ELEM_W;

    typedef logic signed [ELEM_W-1:0] elem_t;

    // Field order matches the configuration word: median in the upper half.
    typedef struct packed {
        elem_t             median;
        logic [ELEM_W-1:0] index;
    } split_cfg_t;

    function automatic split_cfg_t pack_split(input elem_t median,
                                              input logic [ELEM_W-1:0] index);
        split_cfg_t cfg;
        cfg.median = median;
        cfg.index  = index;
        return cfg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kd_elem_select.sv
`default_nettype none
// ============================================================================
//  Module   : kd_elem_select
//  Purpose  : Combinational NUM_ELEM-way signed element multiplexer.
//  Ports    : patch        in  packed patch, element 0 at LSBs
//             index        in  element number to pick
//             elem         out selected element (most negative if out of range)
//             out_of_range out index >= NUM_ELEM
//  Revision : 1.0 - initial release
// ============================================================================
module kd_elem_select
    import kd_tree_pkg::*;
#(
    parameter int ELEM_WIDTH = ELEM_W,
    parameter int ELEM_COUNT = NUM_ELEM
) (
    input  logic [ELEM_WIDTH*ELEM_COUNT-1:0] patch,
    input  logic [ELEM_WIDTH-1:0]            index,
    output logic signed [ELEM_WIDTH-1:0]     elem,
    output logic                             out_of_range
);

    localparam logic signed [ELEM_WIDTH-1:0] C_ELEM_MIN =
        {1'b1, {(ELEM_WIDTH-1){1'b0}}};

    logic signed [ELEM_WIDTH-1:0] w_elems [ELEM_COUNT];

    generate
        for (genvar g = 0; g < ELEM_COUNT; g++) begin : g_split
            assign w_elems[g] = patch[g*ELEM_WIDTH +: ELEM_WIDTH];
        end
    endgenerate

    // The most negative default means an unmatched index naturally compares
    // below any median; the flag still lets the caller force the left route
    // when the median itself is the most negative value.
    always_comb begin
        elem         = C_ELEM_MIN;
        out_of_range = 1'b1;
        for (int i = 0; i < ELEM_COUNT; i++) begin
            if (index == ELEM_WIDTH'(i)) begin
                elem         = w_elems[i];
                out_of_range = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/kd_tree_internal_node.sv
`default_nettype none
// ============================================================================
//  Module   : kd_tree_internal_node
//  Purpose  : One decision node of a k-d tree. Holds a programmable split
//             (feature index + signed median) and routes each valid patch to
//             exactly one child, forwarding the patch through one register.
//  Ports    : clk          in  clock, rising edge
//             rst_n        in  synchronous active-low reset
//             wen          in  load split configuration from wdata
//             valid        in  patch_in carries a patch
//             wdata        in  {median (signed, upper half), index (lower half)}
//             patch_in     in  packed signed elements, element 0 at LSBs
//             patch_out    out registered copy of patch_in
//             valid_left   out registered left-child strobe
//             valid_right  out registered right-child strobe
//  Revision : 1.0 - initial release
// ============================================================================
module kd_tree_internal_node
    import kd_tree_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int STORAGE_WIDTH = STORAGE_WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wen,
    input  logic                     valid,
    input  logic [STORAGE_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0]    patch_in,
    output logic [DATA_WIDTH-1:0]    patch_out,
    output logic                     valid_left,
    output logic                     valid_right
);

    localparam int C_ELEM_W   = STORAGE_WIDTH / 2;
    localparam int C_NUM_ELEM = DATA_WIDTH / C_ELEM_W;

    logic signed [C_ELEM_W-1:0] median_q;
    logic        [C_ELEM_W-1:0] index_q;

    logic signed [C_ELEM_W-1:0] w_elem;
    logic                       w_out_of_range;
    logic                       w_go_left;

    kd_elem_select #(
        .ELEM_WIDTH (C_ELEM_W),
        .ELEM_COUNT (C_NUM_ELEM)
    ) u_elem_select (
        .patch        (patch_in[C_ELEM_W*C_NUM_ELEM-1:0]),
        .index        (index_q),
        .elem         (w_elem),
        .out_of_range (w_out_of_range)
    );

    // Equal to the median goes right. An unconfigured feature slot always
    // goes left so the patch is never lost.
    assign w_go_left = w_out_of_range | (w_elem < median_q);

    // The decision reads the current median_q/index_q, so a wen on the same
    // edge as a valid patch only affects later patches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            median_q    <= '0;
            index_q     <= '0;
            patch_out   <= '0;
            valid_left  <= 1'b0;
            valid_right <= 1'b0;
        end else begin
            if (wen) begin
                median_q <= wdata[2*C_ELEM_W-1:C_ELEM_W];
                index_q  <= wdata[C_ELEM_W-1:0];
            end
            patch_out   <= patch_in;
            valid_left  <= valid & w_go_left;
            valid_right <= valid & ~w_go_left;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kd_tree_internal_node.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_kd_tree_internal_node
//  Purpose  : Directed self-checking bench for kd_tree_internal_node.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kd_tree_internal_node;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wen = 1'b0;
    logic        valid = 1'b0;
    logic [21:0] wdata = '0;
    logic [54:0] patch_in = '0;
    logic [54:0] patch_out;
    logic        valid_left;
    logic        valid_right;

    int checks = 0;
    int failures = 0;

    kd_tree_internal_node #(
        .DATA_WIDTH    (55),
        .STORAGE_WIDTH (22)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wen         (wen),
        .valid       (valid),
        .wdata       (wdata),
        .patch_in    (patch_in),
        .patch_out   (patch_out),
        .valid_left  (valid_left),
        .valid_right (valid_right)
    );

    always #5 clk = ~clk;

    function automatic logic [54:0] mk(input int e4, input int e3, input int e2,
                                       input int e1, input int e0);
        return {11'(e4), 11'(e3), 11'(e2), 11'(e1), 11'(e0)};
    endfunction

    function automatic logic [21:0] cfg(input int median, input int index);
        return {11'(median), 11'(index)};
    endfunction

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wen = 1'b1; valid = 1'b1; wdata = cfg(5, 2);
        patch_in = mk(1, 2, 3, 4, 5);
        step(); step();
        checks++; if (patch_out !== 55'd0) begin failures++; $display("FAIL reset_patch_out got=%h exp=0", patch_out); end
        checks++; if (valid_left !== 1'b0) begin failures++; $display("FAIL reset_valid_left got=%b exp=0", valid_left); end
        checks++; if (valid_right !== 1'b0) begin failures++; $display("FAIL reset_valid_right got=%b exp=0", valid_right); end
        rst_n = 1'b1; wen = 1'b0; valid = 1'b0;
    endtask

    task automatic test_basic_route();
        logic [54:0] p;
        wen = 1'b1; wdata = cfg(2, 1); valid = 1'b0; step();
        wen = 1'b0;
        p = mk(3, 3, 3, 1, 3); valid = 1'b1; patch_in = p; step();
        checks++; if (valid_left !== 1'b1) begin failures++; $display("FAIL basic_lt_left got=%b exp=1", valid_left); end
        checks++; if (valid_right !== 1'b0) begin failures++; $display("FAIL basic_lt_right got=%b exp=0", valid_right); end
        checks++; if (patch_out !== p) begin failures++; $display("FAIL basic_patch_out got=%h exp=%h", patch_out, p); end
        patch_in = mk(3, 3, 3, 3, 3); step();
        checks++; if (valid_left !== 1'b0) begin failures++; $display("FAIL basic_gt_left got=%b exp=0", valid_left); end
        checks++; if (valid_right !== 1'b1) begin failures++; $display("FAIL basic_gt_right got=%b exp=1", valid_right); end
        patch_in = mk(-7, -7, -7, 2, -7); step();
        checks++; if (valid_left !== 1'b0) begin failures++; $display("FAIL basic_eq_left got=%b exp=0", valid_left); end
        checks++; if (valid_right !== 1'b1) begin failures++; $display("FAIL basic_eq_right got=%b exp=1", valid_right); end
        valid = 1'b0;
    endtask

    task automatic test_signed_compare();
        logic [54:0] pats [3];
        logic        exp_left [3];
        pats[0] = mk(0, 9, 9, 9, 9);        exp_left[0] = 1'b1;
        pats[1] = mk(1023, -9, -9, -9, -9); exp_left[1] = 1'b0;
        pats[2] = mk(-1024, 9, 9, 9, 9);    exp_left[2] = 1'b1;
        wen = 1'b1; wdata = cfg(2, 4); valid = 1'b0; step();
        wen = 1'b0; valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            patch_in = pats[i]; step();
            checks++; if (valid_left !== exp_left[i]) begin failures++; $display("FAIL signed_%0d_left got=%b exp=%b", i, valid_left, exp_left[i]); end
            checks++; if (valid_right !== !exp_left[i]) begin failures++; $display("FAIL signed_%0d_right got=%b exp=%b", i, valid_right, !exp_left[i]); end
        end
        valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        wen = 1'b1; wdata = cfg(2, 1); valid = 1'b0; step();
        // New config {2,4} lands on the same edge as the patch.
        wdata = cfg(2, 4); valid = 1'b1; patch_in = mk(1023, 0, 0, 1, 0); step();
        wen = 1'b0;
        checks++; if (valid_left !== 1'b1) begin failures++; $display("FAIL same_edge_old_left got=%b exp=1", valid_left); end
        checks++; if (valid_right !== 1'b0) begin failures++; $display("FAIL same_edge_old_right got=%b exp=0", valid_right); end
        step();
        checks++; if (valid_left !== 1'b0) begin failures++; $display("FAIL same_edge_new_left got=%b exp=0", valid_left); end
        checks++; if (valid_right !== 1'b1) begin failures++; $display("FAIL same_edge_new_right got=%b exp=1", valid_right); end
        valid = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [54:0] p;
        // Median at the most negative value: only the out-of-range rule can send it left.
        wen = 1'b1; wdata = cfg(-1024, 7); valid = 1'b0; step();
        wen = 1'b0; valid = 1'b1; patch_in = mk(500, 400, 300, 200, 100); step();
        checks++; if (valid_left !== 1'b1) begin failures++; $display("FAIL oor_left got=%b exp=1", valid_left); end
        checks++; if (valid_right !== 1'b0) begin failures++; $display("FAIL oor_right got=%b exp=0", valid_right); end
        p = mk(-5, 6, -7, 8, -9); valid = 1'b0; patch_in = p; step();
        checks++; if (valid_left !== 1'b0) begin failures++; $display("FAIL idle_left got=%b exp=0", valid_left); end
        checks++; if (valid_right !== 1'b0) begin failures++; $display("FAIL idle_right got=%b exp=0", valid_right); end
        checks++; if (patch_out !== p) begin failures++; $display("FAIL idle_patch_out got=%h exp=%h", patch_out, p); end
    endtask

    task automatic test_midstream_reset();
        wen = 1'b1; wdata = cfg(100, 3); valid = 1'b1; patch_in = mk(1, 1, 1, 1, 1); step();
        // Reset wins over a simultaneous wen and valid.
        rst_n = 1'b0; wdata = cfg(-5, 3); patch_in = mk(2, 2, 2, 2, 2); step();
        checks++; if (patch_out !== 55'd0) begin failures++; $display("FAIL mid_rst_patch_out got=%h exp=0", patch_out); end
        checks++; if (valid_left !== 1'b0) begin failures++; $display("FAIL mid_rst_left got=%b exp=0", valid_left); end
        checks++; if (valid_right !== 1'b0) begin failures++; $display("FAIL mid_rst_right got=%b exp=0", valid_right); end
        rst_n = 1'b1; wen = 1'b0;
        patch_in = mk(0, 0, 0, 0, -1); step();
        checks++; if (valid_left !== 1'b1) begin failures++; $display("FAIL cleared_neg_left got=%b exp=1", valid_left); end
        checks++; if (valid_right !== 1'b0) begin failures++; $display("FAIL cleared_neg_right got=%b exp=0", valid_right); end
        patch_in = mk(-3, -3, -3, -3, 0); step();
        checks++; if (valid_left !== 1'b0) begin failures++; $display("FAIL cleared_zero_left got=%b exp=0", valid_left); end
        checks++; if (valid_right !== 1'b1) begin failures++; $display("FAIL cleared_zero_right got=%b exp=1", valid_right); end
        valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_route();
        test_signed_compare();
        test_back_to_back();
        test_out_of_range();
        test_midstream_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
